rr_mux: RTL and testbench
=========================

Name: rr_mux

Overview:
- Parametrised CHANNELS-input, N-bit round-robin arbitrating multiplexer with a valid/ready handshake on every input and on the output.
- Single registered output stage: one beat is accepted per cycle from the granted channel and presented with its source index.
- Used wherever several producers share one datapath consumer, such as register-file write-back or a shared bus; it replaces the static select-driven mux trees.

Parameters:
- N, 32, data width per channel in bits.
- CHANNELS, 16, number of input channels; must be >= 2; need not be a power of 2.
- SEL_W, $clog2(CHANNELS), width of the channel index; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  CHANNELS*N  flattened channel data; channel k occupies bits [k*N +: N].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; one-hot or zero.
- out_data  output  N  registered data of the held beat.
- out_sel  output  SEL_W  index of the channel that sourced out_data.
- out_valid  output  1  output beat held.
- out_ready  input  1  consumer accepts.

Behaviour:
- Reset (rst=1 at the edge): out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0. rst has priority over every other event, including a transfer in progress on the same edge; any held beat is dropped.
- Pipeline states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load = !out_valid || out_ready. This is combinational, so in_ready depends combinationally on out_ready.
- Grant (combinational): when load=1, g is the first index with in_valid set, searching ptr, ptr+1, ... CHANNELS-1, 0, ... ptr-1. Wrap is modulo CHANNELS, valid for non-power-of-2 counts.
- in_ready[g]=1 only when load=1 and in_valid[g]=1. All other bits of in_ready are 0. in_ready is all-zero when load=0.
- Input transfer when in_valid[g] && in_ready[g]. On that edge:
  - out_data <= channel g data, out_sel <= g, out_valid <= 1.
  - ptr <= (g == CHANNELS-1) ? 0 : g+1.
- load=1 with no in_valid: out_valid <= 0; out_data and out_sel hold their last value; ptr holds.
- FULL and out_ready=0: out_data, out_sel and out_valid hold, with no change while stalled. ptr holds.
- FULL and out_ready=1 with a requester present: drain and refill on the same edge. This gives a throughput of 1 beat/cycle.
- Latency: 1 cycle from input transfer to out_valid.
- in_valid changes while not granted are legal and carry no penalty.
- Fairness: with all channels continuously valid and out_ready=1, grants follow 0,1,...,CHANNELS-1,0,... Any continuously valid channel is granted within CHANNELS accepted beats.

Optional Feature:
- Macro: RR_MUX_LAST_EN.
- Defined: adds input in_last [CHANNELS] and output out_last [1]. The state machine gains a LOCKED state.
  - A transfer with in_last[g]=0 enters LOCKED on channel g. In LOCKED the grant is forced to g regardless of other valids, and ptr does not advance.
  - A transfer with in_last[g]=1 returns to normal arbitration and sets ptr <= g+1 (mod CHANNELS).
  - out_last is registered alongside out_data and resets to 0.
  - rst clears LOCKED.
- Undefined: no in_last or out_last ports; every beat is an independent packet.

Test Plan:
- Reset: assert rst for 2 cycles while in_valid=all ones → out_valid=0, out_data=0, out_sel=0, in_ready=0 during reset. First grant after release is channel 0.
- Round-robin: CHANNELS=16, all in_valid=1, channel k data=0x1000+k, out_ready=1 → out_sel sequence 0..15,0,1. One beat per cycle; out_data matches out_sel.
- Backpressure: out_ready=0 for 5 cycles with channel 3 (data 0xDEADBEEF) valid → out_valid=1 held, out_data=0xDEADBEEF, out_sel=3, in_ready=0. On release, the next beat follows on the same edge.
- Wrap with non-power-of-2 CHANNELS=5: only channels 4 and 1 valid → grants 4,1,4,1. ptr wraps 4→0 correctly.
- Sparse idle: a single 1-cycle pulse on channel 7 (data 0x7) with out_ready=1 → out_valid high for exactly 1 cycle with out_sel=7, then 0. Reset asserted mid-stream drops the held beat on the next edge.
- RR_MUX_LAST_EN: channel 2 sends a 3-beat packet (last on beat 3) while channel 0 is valid throughout → out_sel 2,2,2 with out_last 0,0,1, then channel 0 is granted.

Source files
------------

// File: rtl/rr_mux_if.sv
// Handshake bundle for rr_mux: CHANNELS valid/ready inputs and one valid/ready output.
// Optional packet framing signals exist only when RR_MUX_LAST_EN is defined.
interface rr_mux_if #(
    parameter int unsigned N        = 32,
    parameter int unsigned CHANNELS = 16
) ();
    localparam int unsigned SEL_W = $clog2(CHANNELS);

    logic [CHANNELS*N-1:0] in_data;
    logic [CHANNELS-1:0]   in_valid;
    logic [CHANNELS-1:0]   in_ready;
    logic [N-1:0]          out_data;
    logic [SEL_W-1:0]      out_sel;
    logic                  out_valid;
    logic                  out_ready;
`ifdef RR_MUX_LAST_EN
    logic [CHANNELS-1:0]   in_last;
    logic                  out_last;

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_sel, out_valid, out_last
    );
    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_sel, out_valid, out_last
    );
`else
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );
`endif
endinterface

// File: rtl/rr_mux.sv
// Round-robin arbitrating mux with a single registered output stage.
// Define RR_MUX_LAST_EN to hold the grant on one channel until its in_last beat.
module rr_mux #(
    parameter int unsigned N        = 32,
    parameter int unsigned CHANNELS = 16
) (
    input logic     clk,
    input logic     rst,
    rr_mux_if.slave bus
);
    localparam int unsigned      SEL_W  = $clog2(CHANNELS);
    localparam logic [SEL_W-1:0] LastCh = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]   ChW    = (SEL_W + 1)'(CHANNELS);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e           r_state, w_state_nxt;
    logic [N-1:0]     r_data, w_data_nxt;
    logic [SEL_W-1:0] r_sel, w_sel_nxt;
    logic [SEL_W-1:0] r_ptr, w_ptr_nxt;

    logic                w_load, w_found, w_xfer;
    logic [SEL_W-1:0]    w_grant, w_idx;
    logic [SEL_W:0]      w_sum;
    logic [N-1:0]        w_grant_data;
    logic [CHANNELS-1:0] w_in_ready;
`ifdef RR_MUX_LAST_EN
    logic             r_last, w_last_nxt;
    logic             r_locked, w_locked_nxt;
    logic [SEL_W-1:0] r_lock_ch, w_lock_ch_nxt;
`endif

    // Reset masks load so in_ready stays low while rst is asserted.
    assign w_load = !rst && ((r_state == StEmpty) || bus.out_ready);
    assign w_xfer = w_load && w_found;

    // Search ptr, ptr+1, ... with modulo-CHANNELS wrap for non-power-of-2 counts.
    always_comb begin
        w_found      = 1'b0;
        w_grant      = '0;
        w_grant_data = '0;
        w_sum        = '0;
        w_idx        = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            w_sum = {1'b0, r_ptr} + (SEL_W + 1)'(i);
            if (w_sum >= ChW) begin
                w_sum = w_sum - ChW;
            end
            w_idx = w_sum[SEL_W-1:0];
            if (!w_found && bus.in_valid[w_idx]) begin
                w_found      = 1'b1;
                w_grant      = w_idx;
                w_grant_data = bus.in_data[w_idx*N +: N];
            end
        end
`ifdef RR_MUX_LAST_EN
        if (r_locked) begin
            w_found      = bus.in_valid[r_lock_ch];
            w_grant      = r_lock_ch;
            w_grant_data = bus.in_data[r_lock_ch*N +: N];
        end
`endif
    end

    always_comb begin
        w_in_ready = '0;
        if (w_xfer) begin
            w_in_ready[w_grant] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_sel_nxt   = r_sel;
        w_ptr_nxt   = r_ptr;
`ifdef RR_MUX_LAST_EN
        w_last_nxt    = r_last;
        w_locked_nxt  = r_locked;
        w_lock_ch_nxt = r_lock_ch;
`endif
        if (w_load) begin
            w_state_nxt = w_found ? StFull : StEmpty;
        end
        if (w_xfer) begin
            w_data_nxt = w_grant_data;
            w_sel_nxt  = w_grant;
            w_ptr_nxt  = (w_grant == LastCh) ? '0 : w_grant + 1'b1;
`ifdef RR_MUX_LAST_EN
            w_last_nxt = bus.in_last[w_grant];
            if (bus.in_last[w_grant]) begin
                w_locked_nxt = 1'b0;
            end else begin
                // Mid-packet: pin the grant and leave ptr where it was.
                w_locked_nxt  = 1'b1;
                w_lock_ch_nxt = w_grant;
                w_ptr_nxt     = r_ptr;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StEmpty;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_sel   <= w_sel_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

`ifdef RR_MUX_LAST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last    <= 1'b0;
            r_locked  <= 1'b0;
            r_lock_ch <= '0;
        end else begin
            r_last    <= w_last_nxt;
            r_locked  <= w_locked_nxt;
            r_lock_ch <= w_lock_ch_nxt;
        end
    end

    assign bus.out_last = r_last;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_data  = r_data;
    assign bus.out_sel   = r_sel;
    assign bus.out_valid = (r_state == StFull);
endmodule

// File: tb/tb_rr_mux.sv
// Directed bench for rr_mux: a 16-channel and a 5-channel instance share clock and reset.
module tb_rr_mux;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    rr_mux_if #(.N(32), .CHANNELS(16)) if16 ();
    rr_mux_if #(.N(32), .CHANNELS(5))  if5 ();

    rr_mux #(.N(32), .CHANNELS(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));
    rr_mux #(.N(32), .CHANNELS(5))  u_dut5  (.clk(clk), .rst(rst), .bus(if5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_data16();
        for (int k = 0; k < 16; k++) if16.in_data[k*32 +: 32] = 32'h1000 + k;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        load_data16();
        if16.in_valid  = '1;
        if16.out_ready = 1'b1;
        rst = 1'b1;
        repeat (2) begin
            tick();
            n_vec++;
            if (if16.out_valid !== 1'b0) begin
                n_err++; $display("FAIL reset_valid: got %b want 0", if16.out_valid);
            end
            n_vec++;
            if (if16.out_data !== 32'h0) begin
                n_err++; $display("FAIL reset_data: got %h want 0", if16.out_data);
            end
            n_vec++;
            if (if16.out_sel !== 4'd0) begin
                n_err++; $display("FAIL reset_sel: got %0d want 0", if16.out_sel);
            end
            n_vec++;
            if (if16.in_ready !== 16'h0) begin
                n_err++; $display("FAIL reset_in_ready: got %h want 0", if16.in_ready);
            end
        end
        rst = 1'b0;
        tick();
        n_vec++;
        if (if16.out_valid !== 1'b1 || if16.out_sel !== 4'd0 || if16.out_data !== 32'h1000) begin
            n_err++;
            $display("FAIL first_grant: got v=%b sel=%0d data=%h want v=1 sel=0 data=00001000",
                     if16.out_valid, if16.out_sel, if16.out_data);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_sel;
        load_data16();
        if16.in_valid  = '1;
        if16.out_ready = 1'b1;
        do_reset();
        for (int b = 0; b < 18; b++) begin
            tick();
            exp_sel = 4'(b % 16);
            n_vec++;
            if (if16.out_valid !== 1'b1 || if16.out_sel !== exp_sel) begin
                n_err++;
                $display("FAIL rr_sel beat %0d: got v=%b sel=%0d want v=1 sel=%0d",
                         b, if16.out_valid, if16.out_sel, exp_sel);
            end
            n_vec++;
            if (if16.out_data !== 32'h1000 + 32'(exp_sel)) begin
                n_err++;
                $display("FAIL rr_data beat %0d: got %h want %h",
                         b, if16.out_data, 32'h1000 + 32'(exp_sel));
            end
        end
        if16.in_valid = '0;
    endtask

    task automatic test_backpressure();
        if16.in_valid  = '0;
        if16.out_ready = 1'b1;
        do_reset();
        if16.in_data[3*32 +: 32] = 32'hDEADBEEF;
        if16.in_valid = 16'h0008;
        tick();
        n_vec++;
        if (if16.out_valid !== 1'b1 || if16.out_sel !== 4'd3) begin
            n_err++; $display("FAIL bp_load: got v=%b sel=%0d want v=1 sel=3",
                              if16.out_valid, if16.out_sel);
        end
        if16.out_ready = 1'b0;
        #1;
        n_vec++;
        if (if16.in_ready !== 16'h0) begin
            n_err++; $display("FAIL bp_ready_comb: got %h want 0", if16.in_ready);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_vec++;
            if (if16.out_valid !== 1'b1 || if16.out_data !== 32'hDEADBEEF ||
                if16.out_sel !== 4'd3 || if16.in_ready !== 16'h0) begin
                n_err++;
                $display("FAIL bp_hold cyc %0d: got v=%b data=%h sel=%0d rdy=%h want 1 deadbeef 3 0",
                         c, if16.out_valid, if16.out_data, if16.out_sel, if16.in_ready);
            end
        end
        if16.in_data[3*32 +: 32] = 32'hCAFEF00D;
        if16.out_ready = 1'b1;
        #1;
        n_vec++;
        if (if16.in_ready !== 16'h0008) begin
            n_err++; $display("FAIL bp_release_ready: got %h want 0008", if16.in_ready);
        end
        tick();
        n_vec++;
        if (if16.out_valid !== 1'b1 || if16.out_data !== 32'hCAFEF00D || if16.out_sel !== 4'd3) begin
            n_err++; $display("FAIL bp_refill: got v=%b data=%h sel=%0d want 1 cafef00d 3",
                              if16.out_valid, if16.out_data, if16.out_sel);
        end
        if16.in_valid = '0;
        tick();
        n_vec++;
        if (if16.out_valid !== 1'b0) begin
            n_err++; $display("FAIL bp_drain: got v=%b want 0", if16.out_valid);
        end
    endtask

    task automatic test_wrap();
        logic [2:0] exp_seq [4];
        exp_seq[0] = 3'd4; exp_seq[1] = 3'd1; exp_seq[2] = 3'd4; exp_seq[3] = 3'd1;
        for (int k = 0; k < 5; k++) if5.in_data[k*32 +: 32] = 32'h500 + k;
        if5.in_valid  = '0;
        if5.out_ready = 1'b1;
        do_reset();
        // One beat on channel 2 moves ptr to 3, so channel 4 wins ahead of channel 1.
        if5.in_valid = 5'b00100;
        tick();
        n_vec++;
        if (if5.out_valid !== 1'b1 || if5.out_sel !== 3'd2) begin
            n_err++; $display("FAIL wrap_pre: got v=%b sel=%0d want v=1 sel=2",
                              if5.out_valid, if5.out_sel);
        end
        if5.in_valid = 5'b10010;
        for (int b = 0; b < 4; b++) begin
            tick();
            n_vec++;
            if (if5.out_valid !== 1'b1 || if5.out_sel !== exp_seq[b] ||
                if5.out_data !== 32'h500 + 32'(exp_seq[b])) begin
                n_err++;
                $display("FAIL wrap beat %0d: got v=%b sel=%0d data=%h want sel=%0d",
                         b, if5.out_valid, if5.out_sel, if5.out_data, exp_seq[b]);
            end
        end
        if5.in_valid = '0;
        tick();
    endtask

    task automatic test_sparse_idle();
        if16.in_valid  = '0;
        if16.out_ready = 1'b1;
        do_reset();
        tick();
        n_vec++;
        if (if16.out_valid !== 1'b0) begin
            n_err++; $display("FAIL idle_valid: got %b want 0", if16.out_valid);
        end
        if16.in_data[7*32 +: 32] = 32'h7;
        if16.in_valid = 16'h0080;
        tick();
        if16.in_valid = '0;
        n_vec++;
        if (if16.out_valid !== 1'b1 || if16.out_sel !== 4'd7 || if16.out_data !== 32'h7) begin
            n_err++; $display("FAIL pulse_beat: got v=%b sel=%0d data=%h want 1 7 7",
                              if16.out_valid, if16.out_sel, if16.out_data);
        end
        tick();
        n_vec++;
        if (if16.out_valid !== 1'b0 || if16.out_sel !== 4'd7 || if16.out_data !== 32'h7) begin
            n_err++; $display("FAIL pulse_end: got v=%b sel=%0d data=%h want 0 7 7",
                              if16.out_valid, if16.out_sel, if16.out_data);
        end
        load_data16();
        if16.in_valid = '1;
        tick();
        n_vec++;
        if (if16.out_valid !== 1'b1 || if16.out_sel !== 4'd8 || if16.out_data !== 32'h1008) begin
            n_err++; $display("FAIL midstream_beat: got v=%b sel=%0d data=%h want 1 8 00001008",
                              if16.out_valid, if16.out_sel, if16.out_data);
        end
        rst = 1'b1;
        tick();
        n_vec++;
        if (if16.out_valid !== 1'b0 || if16.out_sel !== 4'd0 || if16.out_data !== 32'h0) begin
            n_err++; $display("FAIL midstream_reset: got v=%b sel=%0d data=%h want 0 0 0",
                              if16.out_valid, if16.out_sel, if16.out_data);
        end
        rst = 1'b0;
        if16.in_valid = '0;
        tick();
    endtask

`ifdef RR_MUX_LAST_EN
    task automatic test_last();
        logic [31:0] exp_data [4];
        logic        exp_last [4];
        logic [3:0]  exp_sel  [4];
        exp_sel[0] = 4'd2; exp_sel[1] = 4'd2; exp_sel[2] = 4'd2; exp_sel[3] = 4'd0;
        exp_last[0] = 1'b0; exp_last[1] = 1'b0; exp_last[2] = 1'b1; exp_last[3] = 1'b0;
        exp_data[0] = 32'h2A1; exp_data[1] = 32'h2A2; exp_data[2] = 32'h2A3; exp_data[3] = 32'hA0;
        if16.in_valid  = '0;
        if16.in_last   = '0;
        if16.out_ready = 1'b1;
        do_reset();
        // A beat on channel 1 moves ptr to 2 so the packet on channel 2 starts first.
        if16.in_valid = 16'h0002;
        if16.in_last  = 16'h0002;
        tick();
        if16.in_last = '0;
        if16.in_data[0*32 +: 32] = 32'hA0;
        if16.in_valid = 16'h0005;
        for (int b = 0; b < 4; b++) begin
            if (b < 3) if16.in_data[2*32 +: 32] = 32'h2A1 + 32'(b);
            if (b == 2) if16.in_last = 16'h0004;
            if (b == 3) begin
                if16.in_valid = 16'h0001;
                if16.in_last  = '0;
            end
            tick();
            n_vec++;
            if (if16.out_valid !== 1'b1 || if16.out_sel !== exp_sel[b] ||
                if16.out_last !== exp_last[b] || if16.out_data !== exp_data[b]) begin
                n_err++;
                $display("FAIL last beat %0d: got v=%b sel=%0d last=%b data=%h want sel=%0d last=%b data=%h",
                         b, if16.out_valid, if16.out_sel, if16.out_last, if16.out_data,
                         exp_sel[b], exp_last[b], exp_data[b]);
            end
        end
        if16.in_valid = '0;
        tick();
    endtask
`endif

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        if16.in_data = '0; if16.in_valid = '0; if16.out_ready = 1'b0;
        if5.in_data  = '0; if5.in_valid  = '0; if5.out_ready  = 1'b0;
`ifdef RR_MUX_LAST_EN
        if16.in_last = '0;
        if5.in_last  = '0;
`endif
        test_reset();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_sparse_idle();
`ifdef RR_MUX_LAST_EN
        test_last();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
